// File: rtl/risc_uart_defs.sv
// Shared definitions for the risc out-bus UART transmitter.
// UART_TX_PARITY_EN adds an even-parity state to the frame.
package risc_uart_defs;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

endpackage

// File: rtl/risc_out_fifo.sv
// Word FIFO between the risc out bus and the UART serializer.
// Extra pointer MSB distinguishes full from empty.
module risc_out_fifo
    import risc_uart_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop on the same edge frees the slot a full-FIFO push needs
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/risc_out_uart_tx.sv
// Streams risc out-bus words off-chip, 4 bytes LSB first, 8N1 UART.
// Define UART_TX_PARITY_EN for an even-parity bit (11-bit frames).
module risc_out_uart_tx
    import risc_uart_defs::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] out_data,
    input  logic        out_we,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    state_t        state, n_state;
    logic [BW-1:0] baud, n_baud;
    logic [2:0]    bit_idx, n_bit;
    logic [1:0]    byte_idx, n_byte;
    logic [31:0]   shreg, n_shreg;
    logic [31:0]   rdata;
    logic          empty;
    logic          pop;
    logic          tx_next;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          par, n_par;
`endif

    risc_out_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_we),
        .pop   (pop),
        .wdata (out_data),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (empty)
    );

    assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE) || !empty;

    always_comb begin
        n_state = state;
        n_baud  = baud + 1'b1;
        n_bit   = bit_idx;
        n_byte  = byte_idx;
        n_shreg = shreg;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        n_par   = par;
`endif
        unique case (state)
            IDLE: begin
                n_baud = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    n_shreg = rdata;
                    n_byte  = '0;
                    n_state = START;
                end
            end
            START: begin
`ifdef UART_TX_PARITY_EN
                n_par = 1'b0;
`endif
                if (baud_end) begin
                    n_baud  = '0;
                    n_bit   = '0;
                    n_state = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    n_baud  = '0;
                    n_shreg = shreg >> 1;
`ifdef UART_TX_PARITY_EN
                    n_par   = par ^ shreg[0];
`endif
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        n_state = PARITY;
`else
                        n_state = STOP;
`endif
                    end else begin
                        n_bit = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    n_baud  = '0;
                    n_state = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    n_baud = '0;
                    if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                        n_byte  = byte_idx + 1'b1;
                        n_state = START;
                    end else begin
                        n_state = IDLE;
                    end
                end
            end
            default: n_state = IDLE;
        endcase
    end

    // tx is registered from the next state so it changes with the state
    always_comb begin
        tx_next = 1'b1;
        unique case (n_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = n_shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = n_par;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= n_state;
            baud     <= n_baud;
            bit_idx  <= n_bit;
            byte_idx <= n_byte;
            shreg    <= n_shreg;
            tx       <= tx_next;
            if (out_we && fifo_full && !pop) overflow <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= n_par;
`endif
        end
    end

endmodule

// File: tb/tb_risc_out_uart_tx.sv
// Bench for risc_out_uart_tx: own UART decoder feeding a word scoreboard.
// Build with UART_TX_PARITY_EN to exercise 11-bit parity frames.
module tb_risc_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WORD_CYC = 4 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_we = 1'b0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          n_words = 0;
    logic        par_log[$];

    always #5 clk = ~clk;

    risc_out_uart_tx #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .out_data  (out_data),
        .out_we    (out_we),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    // UART receiver model: samples mid-bit, assembles bytes into words
    int          m_active = 0;
    int          m_cyc = 0;
    int          m_nbyte = 0;
    logic [10:0] m_bits = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_exp;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            m_active = 0;
            m_nbyte  = 0;
        end else if (m_active == 0) begin
            if (tx === 1'b0) begin
                m_active = 1;
                m_cyc    = 0;
            end
        end else begin
            m_cyc++;
            if (m_cyc % CPB == CPB / 2) begin
                m_bits[m_cyc / CPB] = tx;
                if (m_cyc / CPB == FRAME - 1) begin
                    m_active = 0;
                    n_checks++;
                    if (m_bits[0] !== 1'b0 || m_bits[FRAME-1] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL frame: start=%b stop=%b, need 0/1",
                                 m_bits[0], m_bits[FRAME-1]);
                    end
`ifdef UART_TX_PARITY_EN
                    n_checks++;
                    if (m_bits[9] !== ^m_bits[8:1]) begin
                        n_fail++;
                        $display("FAIL parity: byte %h got %b need %b",
                                 m_bits[8:1], m_bits[9], ^m_bits[8:1]);
                    end
                    par_log.push_back(m_bits[9]);
`endif
                    m_word = {m_bits[8:1], m_word[31:8]};
                    m_nbyte++;
                    if (m_nbyte == 4) begin
                        m_nbyte = 0;
                        n_words++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL word: got %h, none expected", m_word);
                        end else begin
                            m_exp = exp_q.pop_front();
                            if (m_word !== m_exp) begin
                                n_fail++;
                                $display("FAIL word: got %h need %h", m_word, m_exp);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w);
        out_data = w;
        out_we   = 1'b1;
        @(posedge clk);
        #1;
        out_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 4000 && (exp_q.size() != 0 || busy !== 1'b0); i++)
            step();
        n_checks++;
        if (i >= 4000) begin
            n_fail++;
            $display("FAIL %s drain: timeout, %0d words left busy=%b",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        int toggles;
        logic last;
        reset = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({tx, busy, fifo_full, overflow} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset outs: tx/busy/full/ovf=%b need 1000",
                     {tx, busy, fifo_full, overflow});
        end
        toggles = 0;
        last = tx;
        repeat (20) begin
            step();
            if (tx !== last) toggles++;
            last = tx;
        end
        n_checks++;
        if (toggles != 0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset idle: %0d tx edges, tx=%b need 0 and 1",
                     toggles, tx);
        end
    endtask

    task automatic test_single();
        int w0;
        w0 = n_words;
        exp_q.push_back(32'h44332211);
        write_word(32'h44332211);
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL latency0: tx=%b at write edge, need 1", tx);
        end
        step();
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL latency1: tx=%b one edge after write, need 0", tx);
        end
        repeat (WORD_CYC - 1) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_end-1: busy=%b need 1", busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end: busy=%b need 0", busy);
        end
        wait_drain("single");
        n_checks++;
        if (n_words - w0 != 1) begin
            n_fail++;
            $display("FAIL single count: %0d words need 1", n_words - w0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(32'(i));
            write_word(32'(i));
        end
        n_checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b fill: full=%b ovf=%b need 1/0", fifo_full, overflow);
        end
        wait_drain("b2b");
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b ovf: overflow=%b need 0", overflow);
        end
    endtask

    task automatic test_overflow();
        // first word leaves for the serializer, next four fill the FIFO
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(32'hA500_0000 + 32'(i));
            write_word(32'hA500_0000 + 32'(i));
        end
        n_checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf set: full=%b ovf=%b need 1/1", fifo_full, overflow);
        end
        wait_drain("ovf");
        n_checks++;
        if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf sticky: ovf=%b full=%b need 1/0", overflow, fifo_full);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'hC0DE_0000 + 32'(i));
            write_word(32'hC0DE_0000 + 32'(i));
        end
        // land the next write on the edge that pops word 1
        repeat (WORD_CYC - 3) step();
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop pre: full=%b need 1", fifo_full);
        end
        exp_q.push_back(32'hC0DE_00FF);
        write_word(32'hC0DE_00FF);
        n_checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop: full=%b ovf=%b need 1/0", fifo_full, overflow);
        end
        wait_drain("fullpop");
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop ovf: overflow=%b need 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(32'h8765_4321);
        write_word(32'h8765_4321);
        exp_q.push_back(32'h1357_9BDF);
        write_word(32'h1357_9BDF);
        repeat (50) step();
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({tx, busy, fifo_full, overflow} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midreset: tx/busy/full/ovf=%b need 1000",
                     {tx, busy, fifo_full, overflow});
        end
        repeat (3) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset rel: tx=%b busy=%b need 1/0", tx, busy);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        write_word(32'hDEAD_BEEF);
        wait_drain("midreset");
    endtask

    task automatic test_parity();
        par_log.delete();
        exp_q.push_back(32'h0000_0007);
        write_word(32'h0000_0007);
        wait_drain("parity");
`ifdef UART_TX_PARITY_EN
        n_checks++;
        if (par_log.size() != 4) begin
            n_fail++;
            $display("FAIL parity count: %0d bits need 4", par_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (par_log[i] !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL parity byte%0d: got %b need %b",
                             i, par_log[i], (i == 0));
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
